// File: rtl/clip_controller.sv
// Record/playback sequencer for the four-clip recorder: detects button presses,
// paces sample-rate accesses into a 4-region clip memory and tracks clip lengths.
module clip_controller #(
   parameter int ADDR_W     = 15,
   parameter int SAMPLE_DIV = 2500
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [4:0]        q,
   output logic [ADDR_W+1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic              recording,
   output logic              playing,
   output logic [1:0]        clip_out,
   output logic              done
);

   localparam int              CNT_W    = $clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W:0]  CLIP_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]  IDX_ONE  = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REC  = 2'd1,
      PLAY = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic                q3_d_reg, q2_d_reg;
   logic [CNT_W-1:0]    div_cnt_reg, div_cnt_next;
   logic [ADDR_W:0]     sample_idx_reg, sample_idx_next;
   logic [ADDR_W+1:0]   mem_addr_reg, mem_addr_next;
   logic                mem_we_reg, mem_we_next;
   logic                mem_re_reg, mem_re_next;
   logic                recording_reg, recording_next;
   logic                playing_reg, playing_next;
   logic [1:0]          clip_out_reg, clip_out_next;
   logic                done_reg, done_next;

   logic                len_we;
   logic [ADDR_W:0]     len_wdata;
   logic [3:0][ADDR_W:0] len_vec;

   logic                soft_rst;
   logic                rec_edge;
   logic                play_edge;
   logic [1:0]          sel;
   logic                tick;
   logic [ADDR_W:0]     cur_len;
   logic [ADDR_W:0]     sel_len;

   assign soft_rst  = q[4];
   assign rec_edge  = q[3] & ~q3_d_reg;
   assign play_edge = q[2] & ~q2_d_reg;
   assign sel       = {q[0], q[1]};
   assign tick      = (div_cnt_reg == DIV_LAST);
   assign cur_len   = len_vec[clip_out_reg];
   assign sel_len   = len_vec[sel];

   // One length register per clip; only the clip latched for the current
   // operation is ever written.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_len
         logic [ADDR_W:0] len_reg;
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               len_reg <= '0;
            end else if (len_we && (clip_out_reg == 2'(gi))) begin
               len_reg <= len_wdata;
            end
         end
         assign len_vec[gi] = len_reg;
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      div_cnt_next    = div_cnt_reg;
      sample_idx_next = sample_idx_reg;
      mem_addr_next   = mem_addr_reg;
      mem_we_next     = 1'b0;
      mem_re_next     = 1'b0;
      clip_out_next   = clip_out_reg;
      done_next       = 1'b0;
      len_we          = 1'b0;
      len_wdata       = sample_idx_reg;

      unique case (state_reg)
         IDLE: begin
            if (!soft_rst) begin
               if (rec_edge) begin
                  clip_out_next   = sel;
                  state_next      = REC;
                  div_cnt_next    = '0;
                  sample_idx_next = '0;
               end else if (play_edge) begin
                  clip_out_next = sel;
                  if (sel_len == '0) begin
                     done_next = 1'b1;
                  end else begin
                     state_next      = PLAY;
                     div_cnt_next    = '0;
                     sample_idx_next = '0;
                  end
               end
            end
         end

         REC: begin
            // A stop press or soft reset keeps whatever has been written so far.
            if (soft_rst || rec_edge) begin
               state_next = IDLE;
               done_next  = 1'b1;
               len_we     = 1'b1;
               len_wdata  = sample_idx_reg;
            end else if (sample_idx_reg == CLIP_LEN) begin
               state_next = IDLE;
               done_next  = 1'b1;
               len_we     = 1'b1;
               len_wdata  = CLIP_LEN;
            end else begin
               div_cnt_next = tick ? '0 : div_cnt_reg + CNT_ONE;
               if (tick) begin
                  mem_we_next     = 1'b1;
                  mem_addr_next   = {clip_out_reg, sample_idx_reg[ADDR_W-1:0]};
                  sample_idx_next = sample_idx_reg + IDX_ONE;
               end
            end
         end

         PLAY: begin
            if (soft_rst || play_edge) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else if (sample_idx_reg == cur_len) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else begin
               div_cnt_next = tick ? '0 : div_cnt_reg + CNT_ONE;
               if (tick) begin
                  mem_re_next     = 1'b1;
                  mem_addr_next   = {clip_out_reg, sample_idx_reg[ADDR_W-1:0]};
                  sample_idx_next = sample_idx_reg + IDX_ONE;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      recording_next = (state_next == REC);
      playing_next   = (state_next == PLAY);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         q3_d_reg       <= 1'b0;
         q2_d_reg       <= 1'b0;
         div_cnt_reg    <= '0;
         sample_idx_reg <= '0;
         mem_addr_reg   <= '0;
         mem_we_reg     <= 1'b0;
         mem_re_reg     <= 1'b0;
         recording_reg  <= 1'b0;
         playing_reg    <= 1'b0;
         clip_out_reg   <= 2'b00;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         q3_d_reg       <= q[3];
         q2_d_reg       <= q[2];
         div_cnt_reg    <= div_cnt_next;
         sample_idx_reg <= sample_idx_next;
         mem_addr_reg   <= mem_addr_next;
         mem_we_reg     <= mem_we_next;
         mem_re_reg     <= mem_re_next;
         recording_reg  <= recording_next;
         playing_reg    <= playing_next;
         clip_out_reg   <= clip_out_next;
         done_reg       <= done_next;
      end
   end

   assign mem_addr  = mem_addr_reg;
   assign mem_we    = mem_we_reg;
   assign mem_re    = mem_re_reg;
   assign recording = recording_reg;
   assign playing   = playing_reg;
   assign clip_out  = clip_out_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_clip_controller.sv
// Directed bench for clip_controller with ADDR_W=3 (8-sample clips) and
// SAMPLE_DIV=4; every expected value below is hand-computed.
module tb_clip_controller;

   localparam int ADDR_W     = 3;
   localparam int SAMPLE_DIV = 4;

   logic              clock;
   logic              reset;
   logic [4:0]        q;
   logic [ADDR_W+1:0] mem_addr;
   logic              mem_we;
   logic              mem_re;
   logic              recording;
   logic              playing;
   logic [1:0]        clip_out;
   logic              done;

   clip_controller #(
      .ADDR_W     (ADDR_W),
      .SAMPLE_DIV (SAMPLE_DIV)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .q         (q),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .recording (recording),
      .playing   (playing),
      .clip_out  (clip_out),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0;
   int we_addr[$], we_cyc[$], re_addr[$], re_cyc[$], done_cyc[$];
   bit rec_seen, play_seen;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic clear_log();
      we_addr.delete(); we_cyc.delete();
      re_addr.delete(); re_cyc.delete();
      done_cyc.delete();
      rec_seen  = 1'b0;
      play_seen = 1'b0;
   endtask

   // One clock; outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      if (mem_we)    begin we_addr.push_back(int'(mem_addr)); we_cyc.push_back(cyc); end
      if (mem_re)    begin re_addr.push_back(int'(mem_addr)); re_cyc.push_back(cyc); end
      if (done)      done_cyc.push_back(cyc);
      if (recording) rec_seen = 1'b1;
      if (playing)   play_seen = 1'b1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_cyc.size() == 0 && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_done_seen"}, int'(done_cyc.size() > 0), 1);
   endtask

   // Expect `cnt` strobes at base+i, each 4*(i+1) cycles after entry, then done.
   task automatic chk_op(input string tag, input int is_rec, input int cnt, input int base);
      int n;
      n = is_rec ? we_addr.size() : re_addr.size();
      chk({tag, "_count"}, n, cnt);
      for (int i = 0; i < n && i < cnt; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), is_rec ? we_addr[i] : re_addr[i], base + i);
         chk($sformatf("%s_cyc%0d", tag, i), (is_rec ? we_cyc[i] : re_cyc[i]) - t0,
             SAMPLE_DIV * (i + 1));
      end
   endtask

   initial begin
      reset = 1'b0;
      q     = 5'b00000;
      #20;
      chk("rst_recording", int'(recording), 0);
      chk("rst_playing",   int'(playing), 0);
      chk("rst_we_re",     int'({mem_we, mem_re}), 0);
      chk("rst_addr",      int'(mem_addr), 0);
      chk("rst_clip_done", int'({clip_out, done}), 0);
      reset = 1'b1;
      step();

      // 1: full record of clip 0, then full playback.
      clear_log();
      q = 5'b01000;
      step();
      t0 = cyc;
      chk("t1_recording", int'(recording), 1);
      step();
      q = 5'b00000;
      wait_done("t1_rec", 60);
      chk_op("t1_we", 1, 8, 0);
      if (done_cyc.size() > 0) chk("t1_done_cyc", done_cyc[0] - t0, 33);
      chk("t1_recording_off", int'(recording), 0);
      step();
      clear_log();
      q = 5'b00100;
      step();
      t0 = cyc;
      chk("t1_playing", int'(playing), 1);
      q = 5'b00000;
      wait_done("t1_play", 60);
      chk_op("t1_re", 0, 8, 0);
      if (done_cyc.size() > 0) chk("t1_play_done_cyc", done_cyc[0] - t0, 33);
      step();

      // 2: clip 1 stopped after 3 writes, then played back.
      clear_log();
      q = 5'b01010;
      step();
      t0 = cyc;
      chk("t2_clip", int'(clip_out), 1);
      q = 5'b00010;
      for (int n = 0; we_addr.size() < 3 && n < 40; n++) step();
      q = 5'b01010;
      step();
      q = 5'b00010;
      wait_done("t2_rec", 10);
      chk_op("t2_we", 1, 3, 8);
      if (done_cyc.size() > 0) chk("t2_done_cyc", done_cyc[0] - t0, 13);
      chk("t2_recording_off", int'(recording), 0);
      step();
      clear_log();
      q = 5'b00110;
      step();
      t0 = cyc;
      q = 5'b00010;
      wait_done("t2_play", 60);
      chk_op("t2_re", 0, 3, 8);
      if (done_cyc.size() > 0) chk("t2_play_done_cyc", done_cyc[0] - t0, 13);
      q = 5'b00000;
      step();

      // 3: empty clip 3 gives only done.
      clear_log();
      q = 5'b00111;
      step();
      chk("t3_done", int'(done), 1);
      chk("t3_clip", int'(clip_out), 3);
      q = 5'b00000;
      repeat (6) step();
      chk("t3_re_count", re_addr.size(), 0);
      chk("t3_play_seen", int'(play_seen), 0);
      chk("t3_done_count", done_cyc.size(), 1);

      // 4: record and play pressed together and held for 50 cycles.
      clear_log();
      q = 5'b01100;
      step();
      t0 = cyc;
      chk("t4_recording", int'(recording), 1);
      chk("t4_playing", int'(playing), 0);
      repeat (49) step();
      chk("t4_we_count", we_addr.size(), 8);
      chk("t4_done_count", done_cyc.size(), 1);
      if (done_cyc.size() > 0) chk("t4_done_cyc", done_cyc[0] - t0, 33);
      chk("t4_play_seen", int'(play_seen), 0);
      chk("t4_recording_end", int'(recording), 0);
      q = 5'b00000;
      step();

      // 5: soft reset during playback of clip 0 after 2 reads.
      clear_log();
      q = 5'b00100;
      step();
      t0 = cyc;
      q = 5'b00000;
      for (int n = 0; re_addr.size() < 2 && n < 40; n++) step();
      q = 5'b10000;
      step();
      chk("t5_playing", int'(playing), 0);
      chk("t5_done", int'(done), 1);
      chk("t5_done_cyc", cyc - t0, 9);
      q = 5'b11000; step();
      q = 5'b10000; step();
      q = 5'b11000; step();
      q = 5'b10000; step();
      q = 5'b00000; step();
      step();
      chk("t5_re_count", re_addr.size(), 2);
      chk("t5_rec_seen", int'(rec_seen), 0);
      chk("t5_done_count", done_cyc.size(), 1);

      // 6: asynchronous reset in the middle of recording clip 2.
      clear_log();
      q = 5'b01001;
      step();
      t0 = cyc;
      chk("t6_clip", int'(clip_out), 2);
      q = 5'b00001;
      repeat (5) step();
      chk("t6_we_count", we_addr.size(), 1);
      if (we_addr.size() > 0) chk("t6_we_addr", we_addr[0], 16);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_async_recording", int'(recording), 0);
      chk("t6_async_addr", int'(mem_addr), 0);
      chk("t6_async_clip", int'(clip_out), 0);
      #2;
      reset = 1'b1;
      q = 5'b00000;
      step();
      chk("t6_after_recording", int'(recording), 0);
      for (int c = 0; c < 4; c++) begin
         logic [1:0] cv;
         cv = 2'(c);
         clear_log();
         q = {3'b001, cv[0], cv[1]};
         step();
         chk($sformatf("t6_play%0d_done", c), int'(done), 1);
         q = 5'b00000;
         repeat (3) step();
         chk($sformatf("t6_play%0d_re", c), re_addr.size(), 0);
         chk($sformatf("t6_play%0d_play_seen", c), int'(play_seen), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clip_controller.md
Name: clip_controller

Overview:
- Record/playback sequencer for the four-clip audio recorder.
- Sits directly downstream of the input synchronizer and consumes its registered 5-bit bus {reset, record, play, clipselectionwr, clipselectionr}.
- Detects button presses and latches the selected clip.
- Paces sample-rate memory accesses into a 4-region clip memory and tracks the recorded length of each clip.

Parameters:
- ADDR_W, 15, sample-index width per clip; one clip holds CLIP_LEN = 2**ADDR_W samples.
- SAMPLE_DIV, 2500, clock cycles per sample period (100 MHz to 40 kHz); must be >= 2.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- q, input, 5, synchronized controls {soft_rst, record, play, sel_lo, sel_hi}, bits [4:0]. Clip index = {q[0], q[1]}, i.e. {switch1, switch0}.
- mem_addr, output, ADDR_W+2, {clip[1:0], sample_idx}.
- mem_we, output, 1, one-cycle write strobe per recorded sample.
- mem_re, output, 1, one-cycle read strobe per played sample.
- recording, output, 1, high while in state REC.
- playing, output, 1, high while in state PLAY.
- clip_out, output, 2, clip latched at start of the current or last operation.
- done, output, 1, one-cycle pulse when an operation ends (normal, early stop, or soft reset).

Behaviour:
- reset low, asynchronous: state = IDLE; all outputs = 0; sample_idx, div_cnt and edge registers = 0; len[0..3] = 0.
- All outputs are registered.
- Edge detect:
  - rec_edge = q[3] & ~q3_d; play_edge = q[2] & ~q2_d. q3_d and q2_d are the previous-cycle samples.
  - A held button produces exactly one edge.
- Soft reset q[4] high, level-sensitive, highest priority:
  - From REC: len[clip] = samples written so far; next state IDLE; done pulses.
  - From PLAY: next state IDLE; done pulses.
  - While q[4] = 1, rec_edge and play_edge are ignored.
- IDLE:
  - On rec_edge: latch clip_out from q[0], q[1]; go to REC; sample_idx = 0, div_cnt = 0.
  - Else on play_edge: latch clip; if len[clip] = 0, stay IDLE and pulse done; otherwise go to PLAY with sample_idx = 0, div_cnt = 0.
  - Simultaneous rec_edge and play_edge: record wins.
- Sample pacing (REC and PLAY):
  - div_cnt counts 0 to SAMPLE_DIV-1 and wraps; a tick occurs when div_cnt = SAMPLE_DIV-1.
  - The strobe (mem_we in REC, mem_re in PLAY) is high in the cycle after the tick, with mem_addr = {clip_out, sample_idx}.
  - sample_idx increments with the strobe.
  - The first strobe occurs SAMPLE_DIV cycles after the state-entry edge.
- REC:
  - After the strobe for sample_idx = CLIP_LEN-1: len[clip] = CLIP_LEN; go to IDLE; done pulses the same cycle as the transition.
  - rec_edge stops early: len[clip] = number of strobes already issued; go to IDLE; done pulses.
  - If rec_edge coincides with a tick, no further write is issued.
  - play_edge is ignored.
- PLAY:
  - After the strobe for sample_idx = len[clip]-1: go to IDLE; done pulses.
  - play_edge stops early (same tick-coincidence rule as REC).
  - rec_edge is ignored.
  - The switches are not re-sampled mid-operation.
- Width rules:
  - sample_idx is ADDR_W+1 bits internally; it never exceeds CLIP_LEN.
  - len entries are ADDR_W+1 bits and saturate at CLIP_LEN.
- In IDLE: mem_addr holds its last value; mem_we = mem_re = 0.

Test Plan:
1. Directed case, ADDR_W=3, SAMPLE_DIV=4:
   - Stimulus: reset low 20 ns, release; pulse q[3] for 2 cycles with q[1:0]=00.
   - Required: recording=1; 8 mem_we pulses spaced 4 cycles apart at addr 0..7; done pulses; recording=0; len[0]=8.
2. Early stop and partial playback:
   - Stimulus: record with {q[0],q[1]}=01 (clip 1); second record press after 3 writes; then play clip 1.
   - Required: writes at addr 8, 9, 10 only; done pulses; play issues exactly 3 mem_re pulses at addr 8..10, then done.
3. Play of an empty clip:
   - Stimulus: play clip 3 with no prior recording.
   - Required: no mem_re; done pulses 1 cycle after the edge; playing never rises.
4. Simultaneous presses and held button:
   - Stimulus: q[3] and q[2] rise in the same cycle in IDLE.
   - Required: REC entered; holding both for 50 cycles produces no further transitions.
5. Soft reset mid-operation:
   - Stimulus: q[4]=1 during PLAY after 2 reads.
   - Required: next cycle state IDLE, playing=0, done pulses; q[3] pulses while q[4]=1 are ignored.
6. Asynchronous reset mid-operation:
   - Stimulus: reset low mid-REC, between clock edges.
   - Required: outputs clear immediately without a clock edge; a subsequent play of any clip gives done only (all len = 0).
